// File: rtl/johnson_decoder.sv
// Johnson-code receiver: validates and decodes each sampled code word, tracks step
// continuity with a HUNT/LOCKING/LOCKED machine and counts errors. Optional stall
// handling for repeated words is enabled by defining JOHNSON_DEC_HOLD_EN.
module johnson_decoder #(
  parameter  int WIDTH    = 4,
  parameter  int LOCK_CNT = 3,
  parameter  int ERR_W    = 8,
  localparam int IDXW     = $clog2(2 * WIDTH)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] code,
  input  logic             err_clr,
  output logic [IDXW-1:0]  idx,
  output logic             idx_valid,
  output logic             locked,
  output logic             step_err,
  output logic             illegal,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int NSTATES = 2 * WIDTH;
  // run counts LOCKING samples and can briefly hold LOCK_CNT+1 on the locking step.
  localparam int RUNW    = $clog2(LOCK_CNT + 2);

  typedef enum logic [1:0] {
    HUNT,
    LOCKING,
    LOCKED
  } state_e;

  state_e            state_q, state_d;
  logic [RUNW-1:0]   run_q, run_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              idx_valid_q, idx_valid_d;
  logic              locked_q, locked_d;
  logic              step_err_q, step_err_d;
  logic              illegal_q, illegal_d;
  logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;

  int                pop;
  logic [WIDTH-1:0]  low_mask, high_mask;
  logic              code_legal;
  logic [IDXW-1:0]   code_idx, exp_idx;
  logic              hold_hit;
  logic              err_event;

  // A legal word is exactly the low-anchored or the high-anchored run of p ones.
  always_comb begin
    pop       = 0;
    low_mask  = '0;
    high_mask = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop = pop + int'(code[i]);
    end
    for (int i = 0; i < WIDTH; i++) begin
      if (i < pop)          low_mask[i]  = 1'b1;
      if (i >= WIDTH - pop) high_mask[i] = 1'b1;
    end
    code_legal = (code == low_mask) || (code == high_mask);
    code_idx   = code[0] ? IDXW'(pop) : IDXW'((NSTATES - pop) % NSTATES);
    exp_idx    = IDXW'((int'(idx_q) + 1) % NSTATES);
  end

`ifdef JOHNSON_DEC_HOLD_EN
  assign hold_hit = (code_idx == idx_q);
`else
  assign hold_hit = 1'b0;
`endif

  // NOTE: every variable gets a default at the top of the block so no path infers a latch.
  always_comb begin
    state_d     = state_q;
    run_d       = run_q;
    idx_d       = idx_q;
    idx_valid_d = idx_valid_q;
    step_err_d  = 1'b0;
    illegal_d   = 1'b0;

    if (en) begin
      if (!code_legal) begin
        illegal_d   = 1'b1;
        idx_valid_d = 1'b0;
        state_d     = HUNT;
        run_d       = '0;
      end else begin
        idx_valid_d = 1'b1;
        idx_d       = code_idx;
        if (state_q == HUNT) begin
          state_d = LOCKING;
          run_d   = RUNW'(1);
        end else if (!hold_hit) begin
          if (code_idx == exp_idx) begin
            if (state_q == LOCKING) begin
              // run includes the capture sample, so LOCK_CNT steps means run == LOCK_CNT here.
              if (int'(run_q) >= LOCK_CNT) state_d = LOCKED;
              run_d = run_q + RUNW'(1);
            end
          end else begin
            step_err_d = 1'b1;
            state_d    = LOCKING;
            run_d      = RUNW'(1);
          end
        end
      end
    end

    err_event = step_err_d | illegal_d;
    err_cnt_d = err_cnt_q;
    if (err_clr) begin
      err_cnt_d = err_event ? ERR_W'(1) : '0;
    end else if (err_event && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERR_W'(1);
    end

    locked_d = (state_d == LOCKED);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= HUNT;
      run_q       <= '0;
      idx_q       <= '0;
      idx_valid_q <= 1'b0;
      locked_q    <= 1'b0;
      step_err_q  <= 1'b0;
      illegal_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      idx_q       <= idx_d;
      idx_valid_q <= idx_valid_d;
      locked_q    <= locked_d;
      step_err_q  <= step_err_d;
      illegal_q   <= illegal_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign idx       = idx_q;
  assign idx_valid = idx_valid_q;
  assign locked    = locked_q;
  assign step_err  = step_err_q;
  assign illegal   = illegal_q;
  assign err_cnt   = err_cnt_q;

endmodule
